// File: rtl/sort_pkg.sv
// ============================================================================
//  Module      : sort_pkg
//  Description : Types and constants shared by the sorter network and the
//                serial emitter. The word type and the default block type
//                live here.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sort_pkg;

    // Word width. The emitter's DATA_W parameter must equal this value.
    localparam int DATA_W = 32;

    // Default block size used by the sorter network.
    localparam int SORT_N = 2;

    typedef logic [DATA_W-1:0] data_t;

    // Sorted block. Element 0 holds the largest word.
    typedef data_t sort_vec_t [SORT_N];

endpackage : sort_pkg

`default_nettype wire

// File: rtl/sort_emit_if.sv
// ============================================================================
//  Module      : sort_emit_if
//  Description : Block-in / word-out handshake bundle for the sort emitter.
//                The slave modport is the emitter side. The master modport
//                is the side that feeds sorted blocks and consumes the
//                word stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sort_emit_if
    import sort_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
);

    // Block input side
    logic               in_valid;
    logic               in_ready;
    data_t              sort_i [N];

    // Word output side
    logic               out_valid;
    logic               out_ready;
    data_t              out_data;
    logic [IDX_W-1:0]   out_index;
    logic               out_last;
    logic               order_err;

    modport slave (
        input  in_valid,
        input  sort_i,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        output order_err
    );

    modport master (
        output in_valid,
        output sort_i,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        input  order_err
    );

endinterface : sort_emit_if

`default_nettype wire

// File: rtl/sort_order_chk.sv
// ============================================================================
//  Module      : sort_order_chk
//  Description : Sticky ordering monitor for the emitted word stream. Each
//                block must come out in non-increasing (unsigned) order. The
//                monitor keeps the previously popped word and flags any pop
//                that is larger than it, except on the first word of a block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sort_order_chk #(
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              pop_i,       // word accepted by consumer
    input  wire logic              first_i,     // popped word is element 0
    input  wire logic [DATA_W-1:0] data_i,      // word being popped
    output logic                   order_err_o  // sticky until reset
);

    logic [DATA_W-1:0] prev_word_q;
    logic              err_q;

    // Remember each popped word and latch any ascending step within a block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_word_q <= '0;
            err_q       <= 1'b0;
        end else if (pop_i) begin
            prev_word_q <= data_i;
            if (!first_i && (data_i > prev_word_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign order_err_o = err_q;

endmodule : sort_order_chk

`default_nettype wire

// File: rtl/sort_emit.sv
// ============================================================================
//  Module      : sort_emit
//  Description : Serialises fully sorted N-wide blocks into a word stream
//                with valid/ready and last-tagging. A ping-pong pair of
//                banks lets a new block be captured while the previous one
//                drains. Back-to-back blocks leave the emitter with no bubble.
//                Build option SORT_EMIT_ORDER_CHECK_EN adds a sticky
//                monitor. The monitor drives order_err when a block does not
//                come out in non-increasing order. Without the option,
//                order_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sort_emit
    import sort_pkg::*;
#(
    parameter int N      = 2,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(N)
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    sort_emit_if.slave  sif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    // Two banks of N words. Each bank has a full flag.
    logic [DATA_W-1:0] buf_q [2][N];
    logic [1:0]        full_q,   full_d;
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;

    logic              accept;
    logic              pop;
    logic              last_pop;

    // A bank can be written only while it is empty. Because wr_sel points at
    // a full bank only when both banks are full, in_ready depends on
    // registered state alone.
    assign sif.in_ready  = ~full_q[wr_sel_q];
    assign sif.out_valid = full_q[rd_sel_q];
    assign sif.out_data  = buf_q[rd_sel_q][idx_q];
    assign sif.out_index = idx_q;
    assign sif.out_last  = (idx_q == LAST_IDX);

    assign accept   = sif.in_valid & sif.in_ready;
    assign pop      = sif.out_valid & sif.out_ready;
    assign last_pop = pop & (idx_q == LAST_IDX);

    // Next-state for the bank flags, the write/read pointers and the word
    // index. A simultaneous accept and last-pop always touch different
    // banks: with one bank full, wr_sel and rd_sel differ.
    always_comb begin
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        idx_d    = idx_q;

        if (accept) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
        end

        if (pop) begin
            if (last_pop) begin
                idx_d            = '0;
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = ~rd_sel_q;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Control state register. Reset discards every buffered block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            idx_q    <= idx_d;
        end
    end

    // Capture an accepted block into the bank selected by wr_sel. Banks are
    // cleared on reset so that out_data reads zero while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < N; w++) begin
                    buf_q[b][w] <= '0;
                end
            end
        end else if (accept) begin
            for (int w = 0; w < N; w++) begin
                buf_q[wr_sel_q][w] <= sif.sort_i[w];
            end
        end
    end

`ifdef SORT_EMIT_ORDER_CHECK_EN
    sort_order_chk #(
        .DATA_W      (DATA_W)
    ) u_order_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .pop_i       (pop),
        .first_i     (idx_q == '0),
        .data_i      (sif.out_data),
        .order_err_o (sif.order_err)
    );
`else
    assign sif.order_err = 1'b0;
`endif

endmodule : sort_emit

`default_nettype wire

// File: tb/tb_sort_emit.sv
// ============================================================================
//  Module      : tb_sort_emit
//  Description : Self-checking bench for sort_emit (N = 2). It runs a table
//                of single-block vectors, hand-written multi-cycle sequences,
//                and a randomized run. A block-queue reference model checks
//                the randomized run.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sort_emit;
    import sort_pkg::*;

    localparam int N     = 2;
    localparam int IDX_W = 1;

`ifdef SORT_EMIT_ORDER_CHECK_EN
    localparam bit ORDER_EN = 1'b1;
`else
    localparam bit ORDER_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sort_emit_if #(.N(N), .IDX_W(IDX_W)) sif ();

    sort_emit #(
        .N      (N),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sif    (sif)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input data_t a, input data_t b, input logic r);
        sif.in_valid  = v;
        sif.sort_i[0] = a;
        sif.sort_i[1] = b;
        sif.out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string name, input data_t d, input int idx);
        chk({name, "_valid"}, sif.out_valid, 1);
        chk({name, "_data"},  sif.out_data,  d);
        chk({name, "_index"}, sif.out_index, idx);
        chk({name, "_last"},  sif.out_last,  (idx == N - 1));
    endtask

    task automatic do_reset();
        drive(0, '0, '0, 0);
        rst_n = 1'b0;
        #2;
        chk("rst_in_ready",  sif.in_ready,  1);
        chk("rst_out_valid", sif.out_valid, 0);
        chk("rst_out_data",  sif.out_data,  0);
        chk("rst_out_index", sif.out_index, 0);
        chk("rst_out_last",  sif.out_last,  0);
        chk("rst_order_err", sif.order_err, 0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Table vectors. Each vector holds one block and a 4-cycle out_ready
    // pattern; bit c of each field applies to cycle c after the accept.
    typedef struct {
        data_t            a;
        data_t            b;
        logic [3:0]       rdy;
        logic [3:0]       ev;
        data_t            ed [4];
        logic [IDX_W-1:0] ei [4];
    } vec_t;

    vec_t tv [3];

    // Reference model for the randomized run: queue of buffered blocks.
    typedef struct {
        data_t w [N];
    } blk_t;

    blk_t q [$];
    int   hpos;
    data_t m_prev;
    logic  m_err;

    initial begin
        data_t full_exp [6];
        logic  full_rdy [6];

        // Vector 0: single block, consumer always ready.
        tv[0].a = 32'h90; tv[0].b = 32'h10; tv[0].rdy = 4'b1111; tv[0].ev = 4'b0011;
        tv[0].ed = '{32'h90, 32'h10, 32'h0, 32'h0};
        tv[0].ei = '{1'b0, 1'b1, 1'b0, 1'b0};
        // Vector 1: out_ready 1,0,1,0 holds word 1 for a cycle.
        tv[1].a = 32'hFFFF_FFFF; tv[1].b = 32'h0; tv[1].rdy = 4'b0101; tv[1].ev = 4'b0111;
        tv[1].ed = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
        tv[1].ei = '{1'b0, 1'b1, 1'b1, 1'b0};
        // Vector 2: out_ready 0,1,0,1 holds each word for one cycle.
        tv[2].a = 32'hDEAD; tv[2].b = 32'h1; tv[2].rdy = 4'b1010; tv[2].ev = 4'b1111;
        tv[2].ed = '{32'hDEAD, 32'hDEAD, 32'h1, 32'h1};
        tv[2].ei = '{1'b0, 1'b0, 1'b1, 1'b1};

        full_exp = '{32'd5, 32'd3, 32'd8, 32'd1, 32'd7, 32'd2};
        full_rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        drive(0, '0, '0, 0);
        #3;
        chk("por_out_valid", sif.out_valid, 0);
        chk("por_in_ready",  sif.in_ready,  1);
        do_reset();

        // ---------------- table-driven single blocks ----------------
        for (int i = 0; i < 3; i++) begin
            drive(1, tv[i].a, tv[i].b, 0);
            chk("tv_accept_ready", sif.in_ready,  1);
            chk("tv_idle_valid",   sif.out_valid, 0);
            tick();
            for (int c = 0; c < 4; c++) begin
                drive(0, '0, '0, tv[i].rdy[c]);
                chk("tv_in_ready", sif.in_ready, 1);
                chk("tv_valid", sif.out_valid, tv[i].ev[c]);
                if (tv[i].ev[c]) begin
                    chk("tv_data",  sif.out_data,  tv[i].ed[c]);
                    chk("tv_index", sif.out_index, tv[i].ei[c]);
                    chk("tv_last",  sif.out_last,  (tv[i].ei[c] == 1'b1));
                end
                tick();
            end
            chk("tv_drained_valid", sif.out_valid, 0);
            chk("tv_drained_ready", sif.in_ready,  1);
        end

        // ---------------- fill to FULL, then drain ----------------
        drive(1, 32'd5, 32'd3, 0);
        chk("full_ready0", sif.in_ready, 1);
        tick();
        drive(1, 32'd8, 32'd1, 0);
        chk("full_ready1", sif.in_ready, 1);
        tick();
        drive(1, 32'd7, 32'd2, 0);
        chk("full_ready2", sif.in_ready, 0);
        chk("full_stall_data", sif.out_data, 5);
        tick();
        for (int k = 0; k < 6; k++) begin
            drive((k <= 2), 32'd7, 32'd2, 1);
            chk("full_in_ready", sif.in_ready, full_rdy[k]);
            chk_word("full_stream", full_exp[k], k % 2);
            tick();
        end
        drive(0, '0, '0, 1);
        chk("full_end_valid", sif.out_valid, 0);
        chk("full_end_ready", sif.in_ready,  1);

        // ---------------- simultaneous accept and last-pop ----------------
        drive(1, 32'h22, 32'h11, 1);
        tick();
        drive(0, '0, '0, 1);
        chk_word("sim_w0", 32'h22, 0);
        tick();
        drive(1, 32'h44, 32'h33, 1);
        chk("sim_ready", sif.in_ready, 1);
        chk_word("sim_w1", 32'h11, 1);
        tick();
        drive(0, '0, '0, 1);
        chk("sim_one_ready", sif.in_ready, 1);
        chk_word("sim_next_w0", 32'h44, 0);
        tick();
        chk_word("sim_next_w1", 32'h33, 1);
        tick();
        chk("sim_end_valid", sif.out_valid, 0);

        // ---------------- reset mid-drain ----------------
        drive(1, 32'hA5A5_0002, 32'h0000_0001, 1);
        tick();
        drive(0, '0, '0, 1);
        chk_word("rmd_w0", 32'hA5A5_0002, 0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmd_async_valid", sif.out_valid, 0);
        chk("rmd_async_data",  sif.out_data,  0);
        chk("rmd_async_index", sif.out_index, 0);
        chk("rmd_async_ready", sif.in_ready,  1);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("rmd_post_valid", sif.out_valid, 0);
            chk("rmd_post_ready", sif.in_ready,  1);
            tick();
        end

        // ---------------- ordering monitor ----------------
        drive(1, 32'h10, 32'h20, 0);
        tick();
        drive(0, '0, '0, 1);
        chk("ord_before", sif.order_err, 0);
        tick();
        chk("ord_after_pop0", sif.order_err, 0);
        tick();
        chk("ord_after_pop1", sif.order_err, ORDER_EN);
        tick();
        tick();
        chk("ord_sticky", sif.order_err, ORDER_EN);
        do_reset();
        chk("ord_cleared", sif.order_err, 0);

        // ---------------- randomized against block-queue model ----------------
        q.delete();
        hpos   = 0;
        m_prev = '0;
        m_err  = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic  iv, r, exp_ir, exp_v;
            data_t w0, w1, t;
            blk_t  nb;
            iv = 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 3) != 0);
            w0 = $urandom();
            w1 = ($urandom_range(0, 3) == 0) ? w0 : $urandom();
            if ($urandom_range(0, 7) != 0 && w1 > w0) begin
                t = w0; w0 = w1; w1 = t;
            end
            drive(iv, w0, w1, r);

            exp_ir = (q.size() < 2);
            exp_v  = (q.size() > 0);
            chk("rnd_in_ready",  sif.in_ready,  exp_ir);
            chk("rnd_out_valid", sif.out_valid, exp_v);
            chk("rnd_order_err", sif.order_err, m_err);
            if (exp_v) begin
                chk("rnd_data",  sif.out_data,  q[0].w[hpos]);
                chk("rnd_index", sif.out_index, hpos);
                chk("rnd_last",  sif.out_last,  (hpos == N - 1));
            end

            if (exp_v && r) begin
                if (ORDER_EN && hpos > 0 && q[0].w[hpos] > m_prev) m_err = 1'b1;
                m_prev = q[0].w[hpos];
                if (hpos == N - 1) begin
                    void'(q.pop_front());
                    hpos = 0;
                end else begin
                    hpos++;
                end
            end
            if (iv && exp_ir) begin
                nb.w[0] = w0;
                nb.w[1] = w1;
                q.push_back(nb);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sort_emit

`default_nettype wire
